decode_issue_ctrl: RTL
======================

// Module: decode_issue_ctrl
// PURPOSE
//  Issue/hazard controller for the decode stage. Keeps a register-busy scoreboard and decides when the
//  decoded instruction may move into execute. Stalls on RAW/WAW hazards and on execute backpressure,
//  and squashes on a branch/jump redirect. Sits between fetch_decode_if and decode_execute_if.
//  Drives the ready and valid strobes that the decode datapath uses.
// PARAMETERS
//  NUM_REGS    32  architectural register count (x0 hardwired zero)
//  REG_ADDR_W  5   register index width, $clog2(NUM_REGS)
//  STAT_W      32  stall-counter width (only with DECODE_ISSUE_STATS_EN)
// PORTS
//  clk          in   1           pipeline clock, all state on posedge
//  rst_n        in   1           synchronous reset, active low
//  id_valid     in   1           decode holds an instruction
//  id_opcode    in   7           opcode_t of decode instruction
//  id_rs1       in   REG_ADDR_W  source 1 index
//  id_rs2       in   REG_ADDR_W  source 2 index
//  id_rd        in   REG_ADDR_W  destination index
//  id_ready     out  1           decode may advance (fd_if.ready)
//  ex_ready     in   1           execute accepts issue slot this cycle
//  issue_valid  out  1           registered; issue slot holds instr (de_if.valid)
//  wb_valid     in   1           writeback retiring a register write
//  wb_rd        in   REG_ADDR_W  register being retired
//  flush        in   1           redirect: squash decode + unaccepted issue slot
//  busy_regs    out  NUM_REGS    scoreboard, bit i = write to xi pending
//  stall_count  out  STAT_W      hazard-stall cycles (DECODE_ISSUE_STATS_EN only)
// BEHAVIOUR
//  Reset (rst_n=0 at posedge): busy_regs=0, issue_valid=0, state=RUN, stall_count=0; id_ready=0 while in reset.
//  Operand use from opcode:
//   - REG_REG: rs1, rs2, rd.
//   - REG_IMM, LOAD, JALR: rs1, rd.
//   - STORE, BRANCH: rs1, rs2.
//   - LUI, AUIPC, JAL: rd.
//   - Unknown opcode: none (never hazards).
//  Index 0 is never a hazard and never set in busy_regs.
//  busy_eff = busy_regs & ~(wb_valid ? onehot(wb_rd) : 0). A same-cycle writeback clears the hazard (no stall).
//  hazard = (use_rs1 & busy_eff[rs1]) | (use_rs2 & busy_eff[rs2]) | (use_rd & busy_eff[rd]) (WAW included).
//  id_ready = rst_n & ~flush & state!=FLUSH & ~hazard & (~issue_valid | ex_ready). Combinational.
//  fire = id_valid & id_ready.
//   - On fire: issue_valid<=1; if use_rd & rd!=0, set busy[rd] and record slot_rd.
//   - Else if ex_ready: issue_valid<=0.
//  Set and clear of the same reg in one cycle: set wins.
//  Issue slot is held unchanged while ex_ready=0 (valid never drops without acceptance).
//  flush:
//   - issue_valid<=0.
//   - If the slot is unaccepted (issue_valid & ~ex_ready), clear busy[slot_rd].
//   - The decode instruction is not fired; next state=FLUSH.
//   - A wb on the same cycle still clears its bit.
//  FSM states (enum):
//   - RUN: no stall.
//   - STALL: hazard & id_valid.
//   - HOLD: ~hazard & issue_valid & ~ex_ready.
//   - FLUSH: one bubble cycle, then RUN.
//   - RUN/STALL/HOLD reevaluated every cycle; flush from any state goes to FLUSH.
//   - Reset mid-stall returns to RUN with an empty scoreboard.
//  Latency: fire at cycle N -> issue_valid=1 at N+1; a dependent instruction fires the cycle its producer's wb_valid arrives.
// CONFIGURATION
//  `DECODE_ISSUE_STATS_EN defined:
//   - stall_count increments each cycle in STALL or HOLD.
//   - Saturates at all-ones; cleared only by reset.
//  Not defined: stall_count port is absent and no counter logic is built.
// STRUCTURE
//  Existing package entries used: opcode_t and the OPCODE_* constants.
//  New package entries:
//   - issue_state_t enum {RUN, STALL, HOLD, FLUSH}.
//   - reg_use_t struct {use_rs1, use_rs2, use_rd}.
//  Sub-module reg_use_decode: opcode -> reg_use_t, combinational.
//  Remainder (scoreboard, slot, FSM, counter) in this module.
// TESTING
//  1 Reset: rst_n=0 for 2 cycles -> busy_regs=0, issue_valid=0, id_ready=0; next cycle id_ready=1.
//  2 RAW: fire ADD x5 (no wb), then SUB x6,x5,x1 -> id_ready=0, state STALL, busy_regs[5]=1.
//    Then wb_valid=1, wb_rd=5 -> SUB fires that cycle and busy[5] ends 0.
//  3 x0: ADDI x0,x0,1 then ADD x1,x0,x0 -> no stall, busy_regs stays 0.
//  4 Backpressure: ex_ready=0 for 3 cycles with slot full -> issue_valid stays 1, id_ready=0, state HOLD.
//    Then ex_ready=1 -> next instruction fires.
//  5 Flush: LW x7 in slot, ex_ready=0, flush=1 -> busy[7]=0, issue_valid=0 next cycle.
//    One FLUSH cycle with id_ready=0, then RUN.
//  6 Stats (macro on): 4 RAW-stall cycles + 3 HOLD cycles -> stall_count=7; with STAT_W=3 -> saturates at 7.

Source files
------------

// File: rtl/decode_issue_ctrl_pkg.sv
// Shared decode-stage types: RV32 base opcodes, issue FSM states, register-use flags.
package decode_issue_ctrl_pkg;

    typedef logic [6:0] opcode_t;

    localparam opcode_t OPCODE_LUI     = 7'b0110111;
    localparam opcode_t OPCODE_AUIPC   = 7'b0010111;
    localparam opcode_t OPCODE_JAL     = 7'b1101111;
    localparam opcode_t OPCODE_JALR    = 7'b1100111;
    localparam opcode_t OPCODE_BRANCH  = 7'b1100011;
    localparam opcode_t OPCODE_LOAD    = 7'b0000011;
    localparam opcode_t OPCODE_STORE   = 7'b0100011;
    localparam opcode_t OPCODE_REG_IMM = 7'b0010011;
    localparam opcode_t OPCODE_REG_REG = 7'b0110011;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        STALL = 2'd1,
        HOLD  = 2'd2,
        FLUSH = 2'd3
    } issue_state_t;

    typedef struct packed {
        logic use_rs1;
        logic use_rs2;
        logic use_rd;
    } reg_use_t;

endpackage

// File: rtl/decode_issue_ctrl_reg_use.sv
// Purpose: maps an opcode to the register operands it reads/writes.
// Latency: purely combinational, zero cycles.
// Backpressure: none; unknown opcodes report no operand use.
module reg_use_decode
    import decode_issue_ctrl_pkg::*;
(
    input  logic [6:0] opcode,
    output reg_use_t   reg_use
);

    always_comb begin
        reg_use = '0;
        case (opcode_t'(opcode))
            OPCODE_REG_REG: reg_use = '{use_rs1: 1'b1, use_rs2: 1'b1, use_rd: 1'b1};
            OPCODE_REG_IMM,
            OPCODE_LOAD,
            OPCODE_JALR:    reg_use = '{use_rs1: 1'b1, use_rs2: 1'b0, use_rd: 1'b1};
            OPCODE_STORE,
            OPCODE_BRANCH:  reg_use = '{use_rs1: 1'b1, use_rs2: 1'b1, use_rd: 1'b0};
            OPCODE_LUI,
            OPCODE_AUIPC,
            OPCODE_JAL:     reg_use = '{use_rs1: 1'b0, use_rs2: 1'b0, use_rd: 1'b1};
            default:        reg_use = '0;
        endcase
    end

endmodule

// File: rtl/decode_issue_ctrl.sv
// Purpose: decode->execute issue control with register-busy scoreboard (RAW/WAW stall, flush squash).
// Latency: fire in cycle N gives issue_valid in N+1; a same-cycle writeback releases a hazard.
// Backpressure: issue slot held while ex_ready=0; id_ready drops. DECODE_ISSUE_STATS_EN adds stall_count.
module decode_issue_ctrl
    import decode_issue_ctrl_pkg::*;
#(
    parameter int NUM_REGS   = 32,
    parameter int REG_ADDR_W = 5,
    parameter int STAT_W     = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  id_valid,
    input  logic [6:0]            id_opcode,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic [REG_ADDR_W-1:0] id_rd,
    output logic                  id_ready,
    input  logic                  ex_ready,
    output logic                  issue_valid,
    input  logic                  wb_valid,
    input  logic [REG_ADDR_W-1:0] wb_rd,
    input  logic                  flush,
    output logic [NUM_REGS-1:0]   busy_regs
`ifdef DECODE_ISSUE_STATS_EN
    ,
    output logic [STAT_W-1:0]     stall_count
`endif
);

    reg_use_t reg_use;

    reg_use_decode u_reg_use_decode (
        .opcode  (id_opcode),
        .reg_use (reg_use)
    );

    logic [NUM_REGS-1:0]   busy_q, busy_d;
    logic                  issue_valid_q, issue_valid_d;
    logic [REG_ADDR_W-1:0] slot_rd_q, slot_rd_d;
    issue_state_t          state_q, state_d;

    logic [NUM_REGS-1:0]   wb_mask;
    logic [NUM_REGS-1:0]   busy_eff;
    logic                  hazard;
    logic                  fire;

    always_comb begin
        wb_mask  = wb_valid ? (NUM_REGS'(1) << wb_rd) : '0;
        busy_eff = busy_q & ~wb_mask;
        hazard   = (reg_use.use_rs1 && (id_rs1 != '0) && busy_eff[id_rs1]) ||
                   (reg_use.use_rs2 && (id_rs2 != '0) && busy_eff[id_rs2]) ||
                   (reg_use.use_rd  && (id_rd  != '0) && busy_eff[id_rd]);
        id_ready = rst_n && !flush && (state_q != FLUSH) && !hazard &&
                   (!issue_valid_q || ex_ready);
        fire     = id_valid && id_ready;
    end

    always_comb begin
        busy_d        = busy_eff;
        issue_valid_d = issue_valid_q;
        slot_rd_d     = slot_rd_q;

        if (flush) begin
            issue_valid_d = 1'b0;
            // Squashed slot will never write back, so release its destination.
            if (issue_valid_q && !ex_ready && (slot_rd_q != '0)) begin
                busy_d[slot_rd_q] = 1'b0;
            end
        end else if (fire) begin
            issue_valid_d = 1'b1;
            slot_rd_d     = reg_use.use_rd ? id_rd : '0;
            if (reg_use.use_rd && (id_rd != '0)) begin
                busy_d[id_rd] = 1'b1;
            end
        end else if (ex_ready) begin
            issue_valid_d = 1'b0;
        end
    end

    always_comb begin
        state_d = RUN;
        if (flush) begin
            state_d = FLUSH;
        end else if (state_q == FLUSH) begin
            state_d = RUN;
        end else if (hazard && id_valid) begin
            state_d = STALL;
        end else if (issue_valid_q && !ex_ready) begin
            state_d = HOLD;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy_q        <= '0;
            issue_valid_q <= 1'b0;
            slot_rd_q     <= '0;
            state_q       <= RUN;
        end else begin
            busy_q        <= busy_d;
            issue_valid_q <= issue_valid_d;
            slot_rd_q     <= slot_rd_d;
            state_q       <= state_d;
        end
    end

    assign busy_regs   = busy_q;
    assign issue_valid = issue_valid_q;

`ifdef DECODE_ISSUE_STATS_EN
    logic [STAT_W-1:0] stall_count_q, stall_count_d;

    always_comb begin
        stall_count_d = stall_count_q;
        if (((state_q == STALL) || (state_q == HOLD)) && (stall_count_q != '1)) begin
            stall_count_d = stall_count_q + STAT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_count_q <= '0;
        end else begin
            stall_count_q <= stall_count_d;
        end
    end

    assign stall_count = stall_count_q;
`else
    logic unused_stat_w;
    assign unused_stat_w = (STAT_W != 0);
`endif

endmodule
